bitwise_logic_pipe: RTL and testbench
=====================================

BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 Parameter: DEPTH, default 2, number of pipeline register stages; legal range 1..4.
REQ-003 Parameter: COUNT_W, default 16, width of the transfer counter.
REQ-004 Out-of-range parameter values SHALL fail elaboration.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  operand beat valid.
REQ-008 in_ready  out  1  block can accept a beat this cycle.
REQ-009 A  in  WIDTH  operand A.
REQ-010 B  in  WIDTH  operand B.
REQ-011 op  in  3  operation select, sampled with A/B.
REQ-012 out_valid  out  1  result beat valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 Y  out  WIDTH  result.
REQ-015 zero  out  1  Y is all zeros.
REQ-016 all_ones  out  1  Y is all ones.
REQ-017 xfer_count  out  COUNT_W  count of completed output transfers.

Function
REQ-018 op encoding SHALL be bitwise: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (B ignored), 7 PASS A.
REQ-019 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-020 Result, zero and all_ones SHALL be computed from A/B/op at input transfer and carried together through DEPTH register stages.
REQ-021 Latency SHALL be exactly DEPTH cycles from input transfer to out_valid, absent backpressure.
REQ-022 Each stage SHALL load when it is empty or its contents advance this cycle; the last stage advances only on output transfer.
REQ-023 in_ready SHALL be combinational: high when stage 1 is empty or stage 1 advances this cycle.
REQ-024 With out_ready held high, throughput SHALL be one beat per cycle, including simultaneous input and output transfer when all stages are full.
REQ-025 While out_valid && !out_ready, Y, zero, all_ones SHALL be held stable.
REQ-026 Beats SHALL leave in acceptance order, with none dropped or duplicated.
REQ-027 When all stages are full and out_ready is low, in_ready SHALL be low; at most DEPTH beats are held.
REQ-028 xfer_count SHALL increment by 1 on each output transfer and saturate at 2^COUNT_W-1 (no wrap).
REQ-029 A/B/op values while in_valid is low SHALL have no effect on any output.

Reset
REQ-030 On rst high at a rising edge, all stage valids SHALL clear, Y=0, zero=0, all_ones=0, xfer_count=0.
REQ-031 Reset during operation SHALL discard in-flight beats; out_valid SHALL be 0 in the cycle after reset and no stale beat SHALL appear later.
REQ-032 No input transfer SHALL occur in a cycle where rst is high; in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 WIDTH=8, DEPTH=2, out_ready=1, A=0xF0, B=0xCC, op 0..7 on consecutive cycles -> Y = C0, FC, 3C, 3F, 03, C3, 0F, F0 in order; the first out_valid comes 2 cycles after the first accept, then one result per cycle.
REQ-034 DEPTH=2, out_ready=0, offer 3 beats -> 2 accepted, then in_ready=0; Y holds the first result; raise out_ready -> all 3 delivered in order; xfer_count=3.
REQ-035 A=0x00, B=0xFF: op AND -> Y=0x00, zero=1, all_ones=0; op OR -> Y=0xFF, zero=0, all_ones=1.
REQ-036 Two beats in flight, rst high for 1 cycle -> out_valid=0, Y=0, xfer_count=0 next cycle; no old beat emerges afterwards.
REQ-037 WIDTH=1, DEPTH=1, op=0, exhaustive A/B (00, 01, 10, 11) -> Y = 0, 0, 0, 1 each one cycle after accept (2-input AND truth table).
REQ-038 COUNT_W=4, 17 output transfers -> xfer_count reads 15 and stays 15.

Source files
------------

// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - bitwise operation unit with a DEPTH-stage valid/ready pipeline and transfer counter
module bitwise_logic_pipe #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Y,
    output logic               zero,
    output logic               all_ones,
    output logic [COUNT_W-1:0] xfer_count
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("bitwise_logic_pipe: WIDTH must be in 1..64");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("bitwise_logic_pipe: DEPTH must be in 1..4");
    end
    if (COUNT_W < 1) begin : g_bad_count_w
        $error("bitwise_logic_pipe: COUNT_W must be at least 1");
    end

    logic [DEPTH-1:0] stg_valid;
    logic [DEPTH-1:0] stg_zero;
    logic [DEPTH-1:0] stg_ones;
    logic [WIDTH-1:0] stg_y [DEPTH];
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] res;
    logic             accept;

    // A stage may load unless it and every stage downstream of it are full
    // while the output is stalled; written in closed form to avoid a ripple loop.
    always_comb begin
        logic full_tail;
        load      = '0;
        full_tail = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            full_tail = 1'b1;
            for (int j = i; j < DEPTH; j++) begin
                full_tail = full_tail & stg_valid[j];
            end
            load[i] = out_ready | ~full_tail;
        end
    end

    assign in_ready = load[0] & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        res = '0;
        case (op)
            3'd0:    res = A & B;
            3'd1:    res = A | B;
            3'd2:    res = A ^ B;
            3'd3:    res = ~(A & B);
            3'd4:    res = ~(A | B);
            3'd5:    res = ~(A ^ B);
            3'd6:    res = ~A;
            default: res = A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid  <= '0;
            stg_zero   <= '0;
            stg_ones   <= '0;
            xfer_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stg_y[i] <= '0;
            end
        end else begin
            if (load[0]) begin
                stg_valid[0] <= accept;
                if (accept) begin
                    stg_y[0]    <= res;
                    stg_zero[0] <= (res == '0);
                    stg_ones[0] <= &res;
                end
            end
            // Data only moves with a valid beat so a stalled or idle stage keeps its contents.
            for (int i = 1; i < DEPTH; i++) begin
                if (load[i]) begin
                    stg_valid[i] <= stg_valid[i-1];
                    if (stg_valid[i-1]) begin
                        stg_y[i]    <= stg_y[i-1];
                        stg_zero[i] <= stg_zero[i-1];
                        stg_ones[i] <= stg_ones[i-1];
                    end
                end
            end
            if (out_valid && out_ready && xfer_count != {COUNT_W{1'b1}}) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

    assign out_valid = stg_valid[DEPTH-1];
    assign Y         = stg_y[DEPTH-1];
    assign zero      = stg_zero[DEPTH-1];
    assign all_ones  = stg_ones[DEPTH-1];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb/tb_bitwise_logic_pipe.sv - self-checking bench for bitwise_logic_pipe (8-bit/2-stage and 1-bit/1-stage instances)
module tb_bitwise_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, iv, ordy, sel;
    logic [7:0] a, b;
    logic [2:0] op;

    logic        ir0, ov0, z0, o0;
    logic [7:0]  y0;
    logic [15:0] xc0;
    logic        ir1, ov1, z1, o1;
    logic [0:0]  y1;
    logic [3:0]  xc1;

    bitwise_logic_pipe #(.WIDTH(8), .DEPTH(2), .COUNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(ir0),
        .A(a), .B(b), .op(op), .out_valid(ov0), .out_ready(ordy & ~sel),
        .Y(y0), .zero(z0), .all_ones(o0), .xfer_count(xc0)
    );

    bitwise_logic_pipe #(.WIDTH(1), .DEPTH(1), .COUNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(ir1),
        .A(a[0]), .B(b[0]), .op(op), .out_valid(ov1), .out_ready(ordy & sel),
        .Y(y1), .zero(z1), .all_ones(o1), .xfer_count(xc1)
    );

    logic        ir, ov, zr, ao;
    logic [7:0]  yv;
    logic [15:0] xc;
    always_comb begin
        ir = sel ? ir1 : ir0;
        ov = sel ? ov1 : ov0;
        zr = sel ? z1 : z0;
        ao = sel ? o1 : o0;
        yv = sel ? {7'b0, y1} : y0;
        xc = sel ? {12'b0, xc1} : xc0;
    end

    typedef struct {
        logic [7:0] y;
        int         acc;
    } item_t;

    item_t      q[$];
    logic [9:0] cap[$];
    int         cap_cyc[$];
    logic [3:0] tt [8];
    logic [7:0] e33 [8];
    logic [7:0] da [3];
    logic [7:0] db [3];
    logic [2:0] dop [3];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         cnt = 0;
    int         first, k, t;
    bit         acc;

    function automatic logic [7:0] mask();
        return sel ? 8'h01 : 8'hFF;
    endfunction

    function automatic int depth();
        return sel ? 1 : 2;
    endfunction

    function automatic int cmax();
        return sel ? 15 : 65535;
    endfunction

    // Reference: each result bit is looked up in the op's 2-input truth table.
    function automatic logic [7:0] ref_op(logic [7:0] x, logic [7:0] z, logic [2:0] o);
        logic [7:0] r;
        logic [3:0] tab;
        tab = tt[o];
        for (int i = 0; i < 8; i++) r[i] = tab[{x[i], z[i]}];
        return r & mask();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(output bit accepted);
        item_t it;
        bit    ev;
        #1;
        ev = (q.size() > 0) && ((cyc - q[0].acc) >= depth());
        chk("out_valid", {31'b0, ov}, {31'b0, ev});
        chk("in_ready", {31'b0, ir}, {31'b0, (ordy || q.size() < depth())});
        chk("xfer_count", {16'b0, xc}, cnt);
        if (ov && ev) begin
            chk("Y", {24'b0, yv}, {24'b0, q[0].y});
            chk("zero", {31'b0, zr}, {31'b0, (q[0].y == 8'h00)});
            chk("all_ones", {31'b0, ao}, {31'b0, (q[0].y == mask())});
        end
        accepted = iv && ir;
        if (ov && ordy) begin
            if (q.size() > 0) void'(q.pop_front());
            cap.push_back({zr, ao, yv});
            cap_cyc.push_back(cyc);
            if (cnt < cmax()) cnt++;
        end
        if (accepted) begin
            it.y   = ref_op(a, b, op);
            it.acc = cyc;
            q.push_back(it);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        iv   = 1'b1;
        a    = 8'($urandom);
        b    = 8'($urandom);
        op   = 3'($urandom);
        ordy = 1'($urandom);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst  = 1'b0;
        iv   = 1'b0;
        q.delete();
        cnt  = 0;
        #1;
        chk("rst_Y", {24'b0, yv}, 0);
        chk("rst_zero", {31'b0, zr}, 0);
        chk("rst_all_ones", {31'b0, ao}, 0);
        chk("rst_out_valid", {31'b0, ov}, 0);
        chk("rst_xfer_count", {16'b0, xc}, 0);
        chk("rst_in_ready", {31'b0, ir}, 1);
    endtask

    initial begin
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
        e33[0] = 8'hC0; e33[1] = 8'hFC; e33[2] = 8'h3C; e33[3] = 8'h3F;
        e33[4] = 8'h03; e33[5] = 8'hC3; e33[6] = 8'h0F; e33[7] = 8'hF0;
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; sel = 1'b0; a = '0; b = '0; op = '0;
        @(negedge clk);

        // All eight ops on F0/CC back to back
        do_reset();
        cap.delete(); cap_cyc.delete();
        ordy = 1'b1; a = 8'hF0; b = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i); iv = 1'b1;
            tick(acc);
            if (i == 0) first = cyc - 1;
            chk("accept_seq", {31'b0, acc}, 1);
        end
        iv = 1'b0;
        repeat (4) tick(acc);
        chk("seq_count", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) chk("seq_Y", {24'b0, cap[i][7:0]}, {24'b0, e33[i]});
        if (cap_cyc.size() > 0) chk("seq_latency", cap_cyc[0] - first, 2);

        // Zero / all-ones flags
        cap.delete();
        a = 8'h00; b = 8'hFF; op = 3'd0; iv = 1'b1;
        tick(acc);
        op = 3'd1;
        tick(acc);
        iv = 1'b0;
        repeat (3) tick(acc);
        chk("flag_count", cap.size(), 2);
        if (cap.size() == 2) begin
            chk("flag_and", {22'b0, cap[0]}, {22'b0, 10'b10_0000_0000});
            chk("flag_or", {22'b0, cap[1]}, {22'b0, 10'b01_1111_1111});
        end

        // Backpressure: three beats offered, two held, then drained in order
        do_reset();
        cap.delete();
        for (int i = 0; i < 3; i++) begin
            da[i] = 8'($urandom); db[i] = 8'($urandom); dop[i] = 3'($urandom);
        end
        ordy = 1'b0; k = 0;
        for (t = 0; t < 6; t++) begin
            iv = (k < 3);
            if (k < 3) begin a = da[k]; b = db[k]; op = dop[k]; end
            tick(acc);
            if (acc) k++;
        end
        chk("bp_accepted", k, 2);
        chk("bp_hold_Y", {24'b0, yv}, {24'b0, ref_op(da[0], db[0], dop[0])});
        ordy = 1'b1;
        for (t = 0; t < 20 && cap.size() < 3; t++) begin
            iv = (k < 3);
            if (k < 3) begin a = da[k]; b = db[k]; op = dop[k]; end
            tick(acc);
            if (acc) k++;
        end
        iv = 1'b0;
        chk("bp_delivered", cap.size(), 3);
        for (int i = 0; i < 3 && i < cap.size(); i++)
            chk("bp_order", {24'b0, cap[i][7:0]}, {24'b0, ref_op(da[i], db[i], dop[i])});
        #1;
        chk("bp_xfer_count", {16'b0, xc}, 3);

        // Reset with two beats in flight
        do_reset();
        ordy = 1'b1; iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick(acc);
        end
        do_reset();
        cap.delete();
        ordy = 1'b1;
        repeat (6) tick(acc);
        chk("stale_beats", cap.size(), 0);

        // Random traffic with random backpressure
        do_reset();
        repeat (300) begin
            iv = 1'($urandom); a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        iv = 1'b0; ordy = 1'b1;
        repeat (4) tick(acc);
        chk("random_drain", q.size(), 0);

        // 1-bit, 1-stage instance: AND truth table
        sel = 1'b1;
        do_reset();
        cap.delete();
        ordy = 1'b1; op = 3'd0;
        for (int i = 0; i < 4; i++) begin
            a = {7'b0, 1'(i >> 1)}; b = {7'b0, 1'(i)}; iv = 1'b1;
            tick(acc);
        end
        iv = 1'b0;
        repeat (2) tick(acc);
        chk("tt_count", cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++)
            chk("tt_Y", {31'b0, cap[i][0]}, (i == 3) ? 1 : 0);

        // Counter saturation at 15
        do_reset();
        ordy = 1'b1; iv = 1'b1;
        repeat (20) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick(acc);
        end
        chk("sat_count", {16'b0, xc}, 15);
        iv = 1'b0;
        repeat (3) tick(acc);
        chk("sat_hold", {16'b0, xc}, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
